// File: rtl/mem_arb_pkg.sv
// Shared types and encodings for the data-RAM port arbiter.
// Imported by the arbiter, its counter and the bench.
package mem_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } arb_state_e;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;
  localparam logic SZ_BYTE  = 1'b0;
  localparam logic SZ_WORD  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Debug/loader master port: valid/ready request plus
// registered read-data return.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);

  logic              valid;
  logic              ready;
  logic              rw;
  logic              size;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;

  modport master (
    output valid,
    output rw,
    output size,
    output addr,
    output wdata,
    input  ready,
    input  rdata,
    input  rvalid
  );

  modport slave (
    input  valid,
    input  rw,
    input  size,
    input  addr,
    input  wdata,
    output ready,
    output rdata,
    output rvalid
  );

endinterface

// File: rtl/mem_port_arbiter_starve_counter.sv
// Counts consecutive cycles the debug master is blocked;
// hit flags the last blocked cycle before a forced stall.
module starve_counter #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  localparam logic [3:0] LIMIT = 4'(MAX_WAIT - 1);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the data RAM between the MEM stage (priority) and
// the debug master, forcing a one-cycle stall on starvation.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              R,
  input  logic              cpu_en,
  input  logic              cpu_rw,
  input  logic              cpu_size,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  mem_port_arbiter_if.slave dbg,
  output logic              stall,
  output logic              ram_e,
  output logic              ram_rw,
  output logic              ram_size,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_di,
  input  logic [DATA_W-1:0] ram_do
);

  arb_state_e state_q;
  arb_state_e state_d;

  logic              stall_q;
  logic              stall_d;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;
  logic              rvalid_q;
  logic              rvalid_d;

  logic dbg_ready;
  logic xfer;
  logic blocked;
  logic wait_clr;
  logic wait_hit;

  assign blocked  = (state_q == IDLE) && dbg.valid && cpu_en;
  assign xfer     = dbg.valid && dbg_ready;
  assign wait_clr = xfer || !dbg.valid || (state_q == STALL);

  starve_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk   (clk),
    .rst_n (R),
    .inc   (blocked),
    .clr   (wait_clr),
    .hit   (wait_hit)
  );

  always_comb begin
    state_d   = state_q;
    dbg_ready = 1'b0;
    ram_e     = cpu_en;
    ram_rw    = cpu_rw;
    ram_size  = cpu_size;
    ram_addr  = cpu_addr;
    ram_di    = cpu_wdata;
    unique case (state_q)
      IDLE: begin
        if (!cpu_en) begin
          dbg_ready = dbg.valid;
          ram_e     = dbg.valid;
          ram_rw    = dbg.rw;
          ram_size  = dbg.size;
          ram_addr  = dbg.addr;
          ram_di    = dbg.wdata;
        end
        if (blocked && wait_hit) begin
          state_d = STALL;
        end
      end
      STALL: begin
        dbg_ready = dbg.valid;
        ram_e     = dbg.valid;
        ram_rw    = dbg.rw;
        ram_size  = dbg.size;
        ram_addr  = dbg.addr;
        ram_di    = dbg.wdata;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset must block any RAM write, even mid-stall.
    if (!R) begin
      ram_e     = 1'b0;
      dbg_ready = 1'b0;
    end
  end

  always_comb begin
    stall_d  = (state_d == STALL);
    rvalid_d = xfer && (dbg.rw == RW_READ);
    rdata_d  = rvalid_d ? ram_do : rdata_q;
  end

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state_q  <= IDLE;
      stall_q  <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      stall_q  <= stall_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign stall      = stall_q;
  assign cpu_rdata  = ram_do;
  assign dbg.ready  = dbg_ready;
  assign dbg.rdata  = rdata_q;
  assign dbg.rvalid = rvalid_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-master arbiter for the single-port 256x8 data RAM. It shares the RAM between the pipeline MEM stage (fixed priority) and a debug/loader master, which uses a valid/ready handshake to preload or inspect memory while the CPU runs. A starvation counter guarantees forward progress for the debug master: after a bounded wait it raises a one-cycle pipeline stall and takes the port.

## Interface
- ADDR_W, 8, RAM byte-address width
- DATA_W, 32, data width (word = 4 bytes)
- MAX_WAIT, 4, consecutive blocked cycles before a forced stall; legal range 1..15
- clk  in  1  rising-edge clock
- R  in  1  asynchronous, active-low reset
- cpu_en  in  1  MEM stage requests RAM (MEM enable)
- cpu_rw  in  1  1 = write, 0 = read
- cpu_size  in  1  1 = word, 0 = byte
- cpu_addr  in  ADDR_W  MEM stage address
- cpu_wdata  in  DATA_W  MEM stage store data
- cpu_rdata  out  DATA_W  ram_do passthrough to MEM stage
- dbg_valid  in  1  debug request pending
- dbg_ready  out  1  debug request granted this cycle
- dbg_rw, dbg_size  in  1 each  same encodings as cpu_*
- dbg_addr  in  ADDR_W; dbg_wdata  in  DATA_W
- dbg_rdata  out  DATA_W  registered read data
- dbg_rvalid  out  1  one-cycle pulse, dbg_rdata valid
- stall  out  1  registered; holds PC, IF_ID, ID_EX, EX_MEM for one cycle
- ram_e, ram_rw, ram_size  out  1 each  to RAM
- ram_addr  out  ADDR_W; ram_di  out  DATA_W; ram_do  in  DATA_W

## Operation
- States: IDLE, STALL.
- IDLE: if cpu_en, CPU owns the RAM; ram_* = cpu_*, dbg_ready = 0. Otherwise dbg_ready = dbg_valid, and ram_* = dbg_* with ram_e = dbg_valid.
- wait_cnt (4 bits): in IDLE it increments on every cycle with dbg_valid && cpu_en. It clears on any debug grant, on !dbg_valid, and on leaving STALL.
- IDLE -> STALL when dbg_valid && cpu_en && wait_cnt == MAX_WAIT-1 at the edge. MAX_WAIT = 1 therefore stalls after the first blocked cycle.
- STALL: stall = 1. cpu_en is ignored, ram_* = dbg_*, dbg_ready = dbg_valid. Always returns to IDLE next edge. The held MEM request is replayed in the following IDLE cycle with priority.
- Handshake: a transfer completes at an edge where dbg_valid && dbg_ready. The dbg_* signals stay stable while valid && !ready, and dbg_valid may not drop before ready. If dbg_valid is low in STALL, the stall cycle passes with ram_e = 0.
- Reads: at the transfer edge ram_do is captured into dbg_rdata and dbg_rvalid = 1 for exactly the next cycle. Writes do not produce dbg_rvalid.
- Back-to-back debug transfers in consecutive IDLE cycles are allowed when cpu_en = 0.
- While R = 0: ram_e = 0, dbg_ready = 0.

## Timing
- Reset values (async, R low): state IDLE, wait_cnt 0, stall 0, dbg_rvalid 0, dbg_rdata 0.
- Reset mid-STALL aborts the debug grant and does not write; stall drops immediately.
- Grant latency: 0 cycles when the CPU is idle. Worst case MAX_WAIT cycles of continuous cpu_en, then grant in the STALL cycle.
- dbg_ready and ram_* are combinational from cpu_en/dbg_* and the state. stall is a flop output, with no combinational path from inputs.
- Read data latency: dbg_rdata/dbg_rvalid arrive 1 cycle after the transfer edge.
- No address wrap handling: word access at 0xFD–0xFF is an RAM-side concern; the arbiter passes the address unchanged.

## Structure
- Shared package mem_arb_pkg: state enum {IDLE, STALL}, constants RW_READ = 0, RW_WRITE = 1, SZ_BYTE = 0, SZ_WORD = 1.
- Sub-module starve_counter holds wait_cnt: inputs inc, clr; output hit (cnt == MAX_WAIT-1); parameter MAX_WAIT.
- Top module holds the FSM, the output muxes and the read-capture register.

## Test plan
- CPU idle, dbg word write 0xDEADBEEF @0x10, then dbg word read @0x10 -> dbg_ready high same cycle both times; dbg_rvalid pulses one cycle after the read with dbg_rdata = 0xDEADBEEF; stall stays 0.
- cpu_en held high with a CPU read @0x20 and dbg read pending, MAX_WAIT = 4 -> dbg_ready low for 4 cycles, stall = 1 in cycle 5, dbg granted in cycle 5, CPU request served again in cycle 6.
- MAX_WAIT = 1, cpu_en and dbg_valid both rise together -> stall asserted on the 2nd cycle only, with exactly one stall pulse.
- Debug request drops while blocked (protocol violation injected, dbg_valid low after 2 cycles) -> wait_cnt clears; no stall occurs.
- Assert R low during STALL with a dbg write of 0x55 @0x30 -> stall = 0 and dbg_rvalid = 0 immediately; a subsequent read shows @0x30 unchanged.
- Alternate cpu_en 1,0,1,0 with dbg_valid high -> dbg granted every cpu-idle cycle, wait_cnt never reaches the limit, stall never asserted.
